// File: rtl/lfsr_encrypt_parity.sv
// lfsr_encrypt_parity
//   Program #1 encryption engine: reads a raw ASCII message plus preamble
//   length, LFSR tap pattern and LFSR seed from data memory, then writes 64
//   LFSR-encrypted bytes (bit 7 = even parity over bits 6:0) to DM[64..127].
//   Memory is combinational-read, so every address is registered one state
//   ahead of the state that consumes the returned data.
//   Optional feature macro: ENC_TAP_CHECK_EN (validate tap pattern, flag TapErr).
module lfsr_encrypt_parity #(
    parameter int unsigned MSG_BASE = 0,
    parameter int unsigned MSG_LEN  = 52,
    parameter int unsigned CFG_PRE  = 61,
    parameter int unsigned CFG_PTRN = 62,
    parameter int unsigned CFG_INIT = 63,
    parameter int unsigned OUT_BASE = 64,
    parameter int unsigned OUT_LEN  = 64,
    parameter int unsigned PRE_MIN  = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemRdData,
    output logic [7:0] MemWrData,
    output logic       MemWrEn,
    output logic       TapErr
);

    localparam logic [7:0] MSG_BASE_B = 8'(MSG_BASE);
    localparam logic [7:0] MSG_LEN_B  = 8'(MSG_LEN);
    localparam logic [7:0] CFG_PRE_B  = 8'(CFG_PRE);
    localparam logic [7:0] CFG_PTRN_B = 8'(CFG_PTRN);
    localparam logic [7:0] CFG_INIT_B = 8'(CFG_INIT);
    localparam logic [7:0] OUT_BASE_B = 8'(OUT_BASE);
    localparam logic [6:0] LAST_IDX   = 7'(OUT_LEN - 1);
    localparam logic [3:0] PRE_MIN_N  = 4'(PRE_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_PRE,
        S_LD_PTRN,
        S_LD_INIT,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t     state_q;
    logic       armed_q;
    logic [3:0] pre_q;
    logic [6:0] ptrn_q;
    logic [6:0] lfsr_q;
    logic [6:0] i_q;
    logic       ack_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       wren_q;

    logic [3:0] pre_d;
    logic [6:0] ptrn_d;
    logic [6:0] seed_d;
    logic [6:0] sub_d;
    logic [6:0] char_d;
    logic [6:0] enc_d;
    logic       fb_d;
    logic [6:0] i_d;
    logic       win_d;
    logic       tap_ok_d;
    logic       tap_err_d;

    // Byte idx lies inside the message window [pre, pre+MSG_LEN).
    function automatic logic in_window(input logic [6:0] idx, input logic [3:0] pre);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = {4'b0000, pre};
        hi = lo + MSG_LEN_B;
        return ({1'b0, idx} >= lo) && ({1'b0, idx} < hi);
    endfunction

    // Read address for byte idx; out-of-window bytes park on MSG_BASE, which
    // is never outside the message area.
    function automatic logic [7:0] rd_addr(input logic [6:0] idx, input logic [3:0] pre);
        if (in_window(idx, pre))
            return MSG_BASE_B + ({1'b0, idx} - {4'b0000, pre});
        else
            return MSG_BASE_B;
    endfunction

    // Datapath helpers: config decode, character offset, encryption and LFSR feedback.
    always_comb begin
        pre_d    = (MemRdData[3:0] < PRE_MIN_N) ? PRE_MIN_N : MemRdData[3:0];
        seed_d   = (MemRdData[6:0] == 7'h00) ? 7'h01 : MemRdData[6:0];
        // Only bits 6:0 of (MemRdData - 0x20) survive, so a 7-bit subtract suffices.
        sub_d    = MemRdData[6:0] - 7'h20;
        win_d    = in_window(i_q, pre_q);
        char_d   = win_d ? sub_d : 7'h00;
        enc_d    = char_d ^ lfsr_q;
        fb_d     = ^(lfsr_q & ptrn_q);
        i_d      = i_q + 7'd1;
        tap_ok_d = 1'b0;
        case (MemRdData[6:0])
            7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
            7'h69, 7'h5C, 7'h7E, 7'h7B: tap_ok_d = 1'b1;
            default:                    tap_ok_d = 1'b0;
        endcase
`ifdef ENC_TAP_CHECK_EN
        ptrn_d    = tap_ok_d ? MemRdData[6:0] : 7'h60;
        tap_err_d = !tap_ok_d;
`else
        ptrn_d    = MemRdData[6:0];
        tap_err_d = 1'b0;
`endif
    end

    // Main control FSM with registered memory-interface outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            pre_q   <= PRE_MIN_N;
            ptrn_q  <= 7'h60;
            lfsr_q  <= 7'h01;
            i_q     <= '0;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q  <= 1'b0;
                    wren_q <= 1'b0;
                    if (armed_q && !Start) begin
                        armed_q <= 1'b0;
                        addr_q  <= CFG_PRE_B;
                        state_q <= S_LD_PRE;
                    end else if (Start) begin
                        armed_q <= 1'b1;
                    end
                end
                S_LD_PRE: begin
                    pre_q   <= pre_d;
                    addr_q  <= CFG_PTRN_B;
                    state_q <= S_LD_PTRN;
                end
                S_LD_PTRN: begin
                    ptrn_q  <= ptrn_d;
                    addr_q  <= CFG_INIT_B;
                    state_q <= S_LD_INIT;
                end
                S_LD_INIT: begin
                    lfsr_q  <= seed_d;
                    i_q     <= '0;
                    addr_q  <= rd_addr(7'd0, pre_q);
                    state_q <= S_RD;
                end
                S_RD: begin
                    wdata_q <= {^enc_d, enc_d};
                    wren_q  <= 1'b1;
                    addr_q  <= OUT_BASE_B + {1'b0, i_q};
                    state_q <= S_WR;
                end
                S_WR: begin
                    wren_q <= 1'b0;
                    lfsr_q <= {lfsr_q[5:0], fb_d};
                    i_q    <= i_d;
                    if (i_q == LAST_IDX) begin
                        ack_q   <= 1'b1;
                        addr_q  <= '0;
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= rd_addr(i_d, pre_q);
                        state_q <= S_RD;
                    end
                end
                S_DONE: begin
                    wren_q <= 1'b0;
                    if (Start) begin
                        ack_q   <= 1'b0;
                        armed_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    wren_q  <= 1'b0;
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ENC_TAP_CHECK_EN
    logic tap_err_q;

    // Tap-pattern error flag: cleared on launch, set when LD_PTRN sees an illegal pattern.
    always_ff @(posedge Clk) begin
        if (Reset)
            tap_err_q <= 1'b0;
        else if (state_q == S_IDLE && armed_q && !Start)
            tap_err_q <= 1'b0;
        else if (state_q == S_LD_PTRN)
            tap_err_q <= tap_err_d;
    end

    assign TapErr = tap_err_q;
`else
    logic unused_tap;
    assign unused_tap = tap_ok_d ^ tap_err_d;
    assign TapErr     = 1'b0;
`endif

    assign Ack       = ack_q;
    assign MemAddr   = addr_q;
    assign MemWrData = wdata_q;
    assign MemWrEn   = wren_q;

endmodule

// File: tb/tb_lfsr_encrypt_parity.sv
// tb_lfsr_encrypt_parity
//   Self-checking bench for lfsr_encrypt_parity. A behavioural model computes
//   the 64 expected output bytes straight from the memory image; directed and
//   $urandom-driven runs are compared byte by byte, plus latency, reset and
//   read-range checks. Honours ENC_TAP_CHECK_EN like the design.
module tb_lfsr_encrypt_parity;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic [7:0] MemAddr;
    logic [7:0] MemRdData;
    logic [7:0] MemWrData;
    logic       MemWrEn;
    logic       TapErr;

    logic [7:0] dm     [0:255];
    logic [7:0] dm_out [0:255];
    int         wr_run [0:255];
    int         exp_out [0:63];
    int         exp_taperr;
    int         run_id;
    int         wr_cnt;
    int         rd_bad;
    logic       busy;
    int         n_checks;
    int         n_fail;

    lfsr_encrypt_parity dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Ack       (Ack),
        .MemAddr   (MemAddr),
        .MemRdData (MemRdData),
        .MemWrData (MemWrData),
        .MemWrEn   (MemWrEn),
        .TapErr    (TapErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign MemRdData = dm[MemAddr];

    always @(posedge Clk) begin
        if (MemWrEn) begin
            dm_out[MemAddr] <= MemWrData;
            wr_run[MemAddr] <= run_id;
        end
    end

    initial begin
        wr_cnt = 0;
        rd_bad = 0;
    end

    always @(negedge Clk) begin
        if (MemWrEn) wr_cnt <= wr_cnt + 1;
        if (busy && !MemWrEn && !(MemAddr < 8'd52 || (MemAddr >= 8'd61 && MemAddr <= 8'd63)))
            rd_bad <= rd_bad + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected output straight from the memory image and the encryption rules.
    task automatic build_expected();
        int unsigned pre, ptrn, lfsr, c, e;
        pre  = dm[61] % 16;
        if (pre < 10) pre = 10;
        ptrn = dm[62] % 128;
        exp_taperr = 0;
`ifdef ENC_TAP_CHECK_EN
        begin
            int unsigned legal [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};
            bit ok = 0;
            foreach (legal[k]) if (legal[k] == ptrn) ok = 1;
            if (!ok) begin
                ptrn = 'h60;
                exp_taperr = 1;
            end
        end
`endif
        lfsr = dm[63] % 128;
        if (lfsr == 0) lfsr = 1;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i >= pre && i < pre + 52)
                c = (int'(dm[i - pre]) + 256 - 32) % 128;
            else
                c = 0;
            e = c ^ lfsr;
            exp_out[i] = int'(($countones(e) % 2) * 128 + e);
            lfsr = (lfsr * 2 + ($countones(lfsr & ptrn) % 2)) % 128;
        end
    endtask

    task automatic load_msg(input string s, input int pre, input int ptrn, input int seed);
        for (int k = 0; k < 61; k++) dm[k] = (k < s.len()) ? s[k] : 8'h20;
        dm[61] = 8'(pre);
        dm[62] = 8'(ptrn);
        dm[63] = 8'(seed);
    endtask

    task automatic load_random(input int pre, input int ptrn, input int seed);
        for (int k = 0; k < 61; k++) dm[k] = 8'($urandom_range(8'h20, 8'h9F));
        dm[61] = 8'(pre);
        dm[62] = 8'(ptrn);
        dm[63] = 8'(seed);
    endtask

    // Arm, launch, wait for Ack, then compare everything the run produced.
    // Entered and left at posedge+1.
    task automatic run_once(input string name);
        int lat;
        int wr0;
        int bad0;
        run_id++;
        wr0  = wr_cnt;
        bad0 = rd_bad;
        build_expected();
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Start = 1'b0;
        busy  = 1'b1;
        lat   = 0;
        while (!Ack && lat < 400) begin
            @(posedge Clk);
            #1;
            lat++;
            if (lat == 40) Start = 1'b1;
            if (lat == 41) Start = 1'b0;
        end
        busy = 1'b0;
        check({name, " latency"}, lat - 1, 131);
        check({name, " taperr"}, int'(TapErr), exp_taperr);
        check({name, " writes"}, wr_cnt - wr0, 64);
        check({name, " rd_range"}, rd_bad - bad0, 0);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s byte %0d", name, i),
                  (wr_run[64 + i] === run_id) ? int'(dm_out[64 + i]) : 'h100, exp_out[i]);
        repeat (3) @(posedge Clk);
        #1;
        check({name, " ack_hold"}, int'(Ack), 1);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        check({name, " ack_clear"}, int'(Ack), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int guard;
        int bad;
        n_checks = 0;
        n_fail   = 0;
        run_id   = 0;
        busy     = 1'b0;
        for (int k = 0; k < 256; k++) dm[k] = 8'h00;

        // Reset together with Start: reset wins, and Start dropping with it must not arm.
        Reset = 1'b1;
        Start = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst Ack", int'(Ack), 0);
        check("rst MemWrEn", int'(MemWrEn), 0);
        check("rst MemAddr", int'(MemAddr), 0);
        check("rst MemWrData", int'(MemWrData), 0);
        check("rst TapErr", int'(TapErr), 0);
        Reset = 1'b0;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("rst_start no_launch", int'(MemAddr), 0);

        // 1: directed message
        load_msg("Mr. Watson, come here. I want to see you.", 10, 'h60, 'h01);
        run_once("t1");
        check("t1 dm64", int'(dm_out[64]), 'h81);
        check("t1 dm69", int'(dm_out[69]), 'hA0);
        check("t1 dm70", int'(dm_out[70]), 'h41);
        check("t1 dm74", int'(dm_out[74]), 'h35);

        // 2: zero seed behaves as seed 01
        load_msg("Mr. Watson, come here. I want to see you.", 10, 'h60, 'h00);
        run_once("t2");
        check("t2 dm64", int'(dm_out[64]), 'h81);

        // 3: short preamble clamps to minimum
        load_random(3, 'h48, 'h2A);
        run_once("t3");

        // 4: longest preamble truncates the message
        load_random(15, 'h78, 'h55);
        run_once("t4");

        // 5: reset mid-run, then a clean relaunch
        load_random(12, 'h72, 'h11);
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Start = 1'b0;
        wr0   = wr_cnt;
        guard = 0;
        while (wr_cnt - wr0 < 20 && guard < 200) begin
            @(posedge Clk);
            #1;
            guard++;
        end
        check("t5 reached byte20", int'(wr_cnt - wr0 >= 20), 1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge Clk);
            if (MemWrEn || Ack) bad++;
        end
        @(posedge Clk);
        #1;
        check("t5 quiet after reset", bad, 0);
        run_once("t5");

        // 6: illegal tap pattern
        load_random(10, 'h55, 'h01);
        run_once("t6");

        // randomized configurations
        for (int r = 0; r < 4; r++) begin
            load_random(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)));
            run_once($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
